ped_crossing_ctrl: RTL
======================

# ped_crossing_ctrl

Pedestrian crossing controller downstream of the traffic-light sequencer. It consumes the one-hot `red`/`green`/`yellow` phase outputs and a synchronised push-button request, and drives the WALK / DON'T-WALK lamps. A pending request is granted only at the start of a red phase. The block also flags illegal light combinations from upstream.

## Interface
- `WALK_CYCLES`, default 2: cycles `walk` is held high per grant, ≥1.
- `FLASH_CYCLES`, default 2: cycles of flashing `dont_walk` after WALK, ≥1.
- `clk` in 1: sole clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `red` in 1: upstream red phase.
- `green` in 1: upstream green phase.
- `yellow` in 1: upstream yellow phase.
- `btn` in 1: pedestrian request, already synchronised, level-sensitive.
- `walk` out 1: WALK lamp.
- `dont_walk` out 1: DON'T-WALK lamp.
- `req_pending` out 1: a request is latched and awaiting grant.
- `abort` out 1: one-cycle pulse when a WALK is cut short.
- `fault` out 1: sticky illegal-input flag.

## Operation
- All outputs are registered.
- Reset values: `walk`=0, `dont_walk`=1, `req_pending`=0, `abort`=0, `fault`=0, state IDLE, counter 0, `red_q`=0.
- Red-rise detect: `red_q` registers `red`, and `red_rise` = `red & ~red_q`.
  - Because `red_q` resets to 0, red already high on the first cycle after reset counts as a rise.
- Request latch:
  - `btn`=1 at an edge sets `req_pending` from the next cycle.
  - `req_pending` clears on the edge that enters WALK.
  - A `btn` seen on that same edge is consumed by the grant and does not re-arm.
  - `btn` during WALK or FLASH re-arms `req_pending` for the next red phase.
- States:
  - IDLE: `walk`=0, `dont_walk`=1.
    - Go to WALK on an edge where `red_rise` is true and (`req_pending` or `btn`) is true.
    - Otherwise stay in IDLE.
    - A request arriving mid-red waits for the next red rise.
  - WALK: `walk`=1, `dont_walk`=0; counter runs 0..`WALK_CYCLES`-1.
    - If `red` is sampled 0 at any edge in WALK: go to IDLE and pulse `abort`=1 for exactly one cycle.
    - Else, when the counter reaches `WALK_CYCLES`-1: go to FLASH and reset the counter.
  - FLASH: `walk`=0.
    - `dont_walk` is 1 on the first FLASH cycle, then toggles every cycle.
    - The counter runs 0..`FLASH_CYCLES`-1, then the block returns to IDLE.
    - FLASH always completes regardless of `red`; it is the clearance interval.
- Fault:
  - More than one of `red`/`green`/`yellow` high at an edge sets `fault`=1 from the next cycle, held until `rst`.
  - The same edge forces state to IDLE.
  - The same edge leaves `req_pending` unchanged but blocks all grants while `fault`=1.
  - All three low is legal; it is the upstream reset/off phase.
- Counter width: `$clog2(max(WALK_CYCLES,FLASH_CYCLES)+1)` bits. It never wraps; it is reset on every state entry.
- `rst` asserted mid-WALK or mid-FLASH returns all state and outputs to reset values on that edge; the pending request is lost.

## Timing
- Grant latency: red rise sampled at edge M → `walk`=1 during cycles M+1 .. M+`WALK_CYCLES`.
- FLASH occupies cycles M+`WALK_CYCLES`+1 .. M+`WALK_CYCLES`+`FLASH_CYCLES`. IDLE (`dont_walk`=1) follows.
- Request latency: `btn` at edge N → `req_pending`=1 in cycle N+1.
- With defaults and a 4-cycle upstream red phase, WALK plus FLASH fits entirely inside red with no abort.
- `abort` asserts in the cycle after `red` is sampled low in WALK, concurrent with `walk` dropping to 0.
- `fault` asserts in the cycle after the illegal sample.

## Test plan
- Reset then idle: `rst`=1 for 2 cycles with all lights low → `walk`=0, `dont_walk`=1, `req_pending`=0, `fault`=0, `abort`=0.
- Normal grant (defaults):
  - Pulse `btn` during green → `req_pending`=1 next cycle.
  - Red rises at edge M → `walk`=1 for cycles M+1..M+2.
  - `dont_walk` reads 1,0 over M+3..M+4, then holds 1; `req_pending`=0 from M+1.
- Same-edge request:
  - `btn`=1 only in the cycle `red` first rises → WALK is granted.
  - `req_pending` stays 0 afterwards.
- Late request:
  - `btn` during the 2nd red cycle → no WALK in this phase; `req_pending` holds 1.
  - WALK is granted at the next red rise.
- Abort (`WALK_CYCLES`=4):
  - Red high for 2 cycles after the rise, then low.
  - → `walk` drops in the cycle after red is sampled low; `abort`=1 for exactly that one cycle; state is IDLE.
- Fault and reset:
  - Drive `red`=`green`=1 for one cycle during WALK → `fault`=1 and `walk`=0 next cycle.
  - Later red rises with a request pending produce no grant.
  - `rst` clears `fault` to 0.

Source files
------------

// File: rtl/ped_crossing_ctrl.sv
// Pedestrian crossing controller: grants WALK at the start of a red phase when a request is
// pending, follows it with a flashing DON'T-WALK clearance, and flags illegal light combinations.
module ped_crossing_ctrl #(
  parameter int unsigned WALK_CYCLES  = 2,
  parameter int unsigned FLASH_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic red,
  input  logic green,
  input  logic yellow,
  input  logic btn,
  output logic walk,
  output logic dont_walk,
  output logic req_pending,
  output logic abort,
  output logic fault
);

  localparam int unsigned CntMax = (WALK_CYCLES > FLASH_CYCLES) ? WALK_CYCLES : FLASH_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] WalkLast  = CntW'(WALK_CYCLES - 1);
  localparam logic [CntW-1:0] FlashLast = CntW'(FLASH_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StWalk, StFlash} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            red_q;
  logic            walk_q, walk_d;
  logic            dont_walk_q, dont_walk_d;
  logic            req_q, req_d;
  logic            abort_q, abort_d;
  logic            fault_q, fault_d;
  logic            red_rise;
  logic            illegal;

  assign red_rise = red & ~red_q;
  assign illegal  = (red & green) | (red & yellow) | (green & yellow);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q | btn;
    abort_d = 1'b0;
    fault_d = fault_q | illegal;

    unique case (state_q)
      StIdle: begin
        if (red_rise && (req_q || btn) && !fault_q) begin
          state_d = StWalk;
          cnt_d   = '0;
          req_d   = 1'b0;  // a btn on the grant edge is consumed here
        end
      end
      StWalk: begin
        if (!red) begin
          state_d = StIdle;
          cnt_d   = '0;
          abort_d = 1'b1;
        end else if (cnt_q == WalkLast) begin
          state_d = StFlash;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StFlash: begin
        // Clearance always runs to completion, independent of red.
        if (cnt_q == FlashLast) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    // Illegal upstream lights override everything and freeze the request latch.
    if (illegal) begin
      state_d = StIdle;
      cnt_d   = '0;
      req_d   = req_q;
      abort_d = 1'b0;
    end

    walk_d = (state_d == StWalk);
    unique case (state_d)
      StWalk:  dont_walk_d = 1'b0;
      StFlash: dont_walk_d = (state_q != StFlash) ? 1'b1 : ~dont_walk_q;
      default: dont_walk_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      red_q       <= 1'b0;
      walk_q      <= 1'b0;
      dont_walk_q <= 1'b1;
      req_q       <= 1'b0;
      abort_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      red_q       <= red;
      walk_q      <= walk_d;
      dont_walk_q <= dont_walk_d;
      req_q       <= req_d;
      abort_q     <= abort_d;
      fault_q     <= fault_d;
    end
  end

  assign walk        = walk_q;
  assign dont_walk   = dont_walk_q;
  assign req_pending = req_q;
  assign abort       = abort_q;
  assign fault       = fault_q;

endmodule
